// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register: valid/ready handshake, optional skid entry,
// synchronous flush to a NOP bubble and saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_FIELDS  = 5,
  parameter int                    INSTR_FIELD = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013,
  parameter int                    SKID        = 1,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                             clk,
  input  logic                             i_rst,
  input  logic                             i_flush,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [NUM_FIELDS*DATA_WIDTH-1:0] i_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [NUM_FIELDS*DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]             o_stall_cnt,
  output logic [CNT_WIDTH-1:0]             o_bubble_cnt
);

  localparam int TOT_W = NUM_FIELDS * DATA_WIDTH;
  // Stored value of an empty stage: NOP in the instruction field, zeros elsewhere.
  localparam logic [TOT_W-1:0] BUBBLE = TOT_W'(NOP_INSTR) << (INSTR_FIELD * DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_SKID_FULL = 2'd2
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic                 en);
    logic [CNT_WIDTH-1:0] res;
    if (en && (cnt != {CNT_WIDTH{1'b1}})) begin
      res = cnt + CNT_WIDTH'(1);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [TOT_W-1:0]   main_r, main_nxt_s;
  logic [TOT_W-1:0]   skid_r, skid_nxt_s;
  logic               valid_r, valid_nxt_s;
  logic               ready_r, ready_nxt_s;
  logic               ready_s;
  logic               accept_s;
  logic               deliver_s;
  logic [CNT_WIDTH-1:0] stall_cnt_r;
  logic [CNT_WIDTH-1:0] bubble_cnt_r;

  // With a skid entry o_ready is a flop; without it, it looks through to i_ready.
  assign ready_s   = (SKID != 0) ? ready_r : (~valid_r | i_ready);
  assign accept_s  = i_valid & ready_s;
  assign deliver_s = valid_r & i_ready;

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_r <= ST_EMPTY;
      main_r  <= BUBBLE;
      skid_r  <= BUBBLE;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      main_r  <= main_nxt_s;
      skid_r  <= skid_nxt_s;
      valid_r <= valid_nxt_s;
      ready_r <= ready_nxt_s;
    end
  end

  // Next-state and next-storage logic; flush overrides the handshake.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (i_flush) begin
      state_nxt_s = ST_EMPTY;
      main_nxt_s  = BUBBLE;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            main_nxt_s  = i_data;
            state_nxt_s = ST_FULL;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (accept_s && deliver_s) begin
            main_nxt_s = i_data;
          end else if (accept_s) begin
            if (SKID != 0) begin
              skid_nxt_s  = i_data;
              state_nxt_s = ST_SKID_FULL;
            end else begin
              main_nxt_s = i_data;
            end
          end else if (deliver_s) begin
            main_nxt_s  = BUBBLE;
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        ST_SKID_FULL: begin
          if (deliver_s) begin
            main_nxt_s  = skid_r;
            state_nxt_s = ST_FULL;
          end else begin
            state_nxt_s = ST_SKID_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
          main_nxt_s  = BUBBLE;
        end
      endcase
    end
  end

  // Registered handshake outputs decoded from the next state.
  always_comb begin
    valid_nxt_s = 1'b0;
    ready_nxt_s = 1'b1;
    case (state_nxt_s)
      ST_EMPTY: begin
        valid_nxt_s = 1'b0;
        ready_nxt_s = 1'b1;
      end
      ST_FULL: begin
        valid_nxt_s = 1'b1;
        ready_nxt_s = 1'b1;
      end
      ST_SKID_FULL: begin
        valid_nxt_s = 1'b1;
        ready_nxt_s = 1'b0;
      end
      default: begin
        valid_nxt_s = 1'b0;
        ready_nxt_s = 1'b1;
      end
    endcase
  end

  // Saturating performance counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      stall_cnt_r  <= {CNT_WIDTH{1'b0}};
      bubble_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      stall_cnt_r  <= sat_inc(stall_cnt_r, valid_r & ~i_ready);
      bubble_cnt_r <= sat_inc(bubble_cnt_r, ~valid_r & i_ready);
    end
  end

  assign o_ready      = ready_s;
  assign o_valid      = valid_r;
  assign o_data       = main_r;
  assign o_stall_cnt  = stall_cnt_r;
  assign o_bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: table of per-cycle vectors plus scoreboards for the
// skid (SKID=1), narrow-counter and single-entry (SKID=0) variants.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int NF = 5;
  localparam int TW = DW * NF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus for the SKID=1 instances
  logic          rst, flush, valid, ready;
  logic [TW-1:0] data;
  logic          o_ready_a, o_valid_a, o_ready_s, o_valid_s;
  logic [TW-1:0] o_data_a, o_data_s;
  logic [15:0]   stall_a, bubble_a;
  logic [3:0]    stall_s, bubble_s;

  // single-entry instance
  logic          flush_b, valid_b, ready_b;
  logic [TW-1:0] data_b, o_data_b;
  logic          o_ready_b, o_valid_b;
  logic [15:0]   stall_b, bubble_b;

  pipe_stage_reg #(.SKID(1), .CNT_WIDTH(16)) dut (
    .clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready_a),
    .i_data(data), .o_valid(o_valid_a), .i_ready(ready), .o_data(o_data_a),
    .o_stall_cnt(stall_a), .o_bubble_cnt(bubble_a));

  pipe_stage_reg #(.SKID(1), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready_s),
    .i_data(data), .o_valid(o_valid_s), .i_ready(ready), .o_data(o_data_s),
    .o_stall_cnt(stall_s), .o_bubble_cnt(bubble_s));

  pipe_stage_reg #(.SKID(0), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .i_rst(rst), .i_flush(flush_b), .i_valid(valid_b), .o_ready(o_ready_b),
    .i_data(data_b), .o_valid(o_valid_b), .i_ready(ready_b), .o_data(o_data_b),
    .o_stall_cnt(stall_b), .o_bubble_cnt(bubble_b));

  typedef struct packed {
    logic       rst;
    logic       flush;
    logic       valid;
    logic       ready;
    logic [7:0] f0;
    logic       exp_valid;
    logic       exp_ready;
    logic [7:0] exp_f0;
    logic [15:0] exp_stall;
  } vec_t;

  vec_t          tbl [25];
  logic [TW-1:0] qa[$];
  logic [TW-1:0] qb[$];
  logic [TW-1:0] bubble_c;
  int            n_checks = 0;
  int            n_errors = 0;
  int            m_stall_a, m_bubble_a, m_stall_s, m_bubble_s, m_stall_b, m_bubble_b;
  int            delivered_b;

  function automatic logic [TW-1:0] mk(input logic [7:0] f0);
    logic [TW-1:0] d;
    for (int k = 0; k < NF; k++) d[k*DW +: DW] = {8'(k), 16'hBEEF, f0};
    return d;
  endfunction

  function automatic int sat(input int c, input logic en, input int maxv);
    return (en && c < maxv) ? c + 1 : c;
  endfunction

  task automatic chk(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Compare every instance against its model at the negedge, then advance the models
  // with the handshake that the coming posedge will perform.
  task automatic cycle(input logic mon);
    logic ev, er, del, acc, evb, erb, delb, accb;
    @(negedge clk);
    ev  = (qa.size() != 0);
    er  = (qa.size() < 2);
    evb = (qb.size() != 0);
    erb = (qb.size() == 0) || ready_b;
    if (mon) begin
      chk("a_valid",  TW'(o_valid_a), TW'(ev));
      chk("a_ready",  TW'(o_ready_a), TW'(er));
      chk("a_data",   o_data_a, ev ? qa[0] : bubble_c);
      chk("a_stall",  TW'(stall_a), TW'(m_stall_a));
      chk("a_bubble", TW'(bubble_a), TW'(m_bubble_a));
      chk("s_data",   o_data_s, ev ? qa[0] : bubble_c);
      chk("s_stall",  TW'(stall_s), TW'(m_stall_s));
      chk("s_bubble", TW'(bubble_s), TW'(m_bubble_s));
      chk("b_valid",  TW'(o_valid_b), TW'(evb));
      chk("b_ready",  TW'(o_ready_b), TW'(erb));
      chk("b_data",   o_data_b, evb ? qb[0] : bubble_c);
      chk("b_stall",  TW'(stall_b), TW'(m_stall_b));
      chk("b_bubble", TW'(bubble_b), TW'(m_bubble_b));
    end
    if (rst) begin
      qa.delete(); qb.delete();
      m_stall_a = 0; m_bubble_a = 0; m_stall_s = 0; m_bubble_s = 0;
      m_stall_b = 0; m_bubble_b = 0;
    end else begin
      m_stall_a  = sat(m_stall_a,  ev & ~ready, 65535);
      m_bubble_a = sat(m_bubble_a, ~ev & ready, 65535);
      m_stall_s  = sat(m_stall_s,  ev & ~ready, 15);
      m_bubble_s = sat(m_bubble_s, ~ev & ready, 15);
      m_stall_b  = sat(m_stall_b,  evb & ~ready_b, 65535);
      m_bubble_b = sat(m_bubble_b, ~evb & ready_b, 65535);
      del = ev & ready;
      acc = valid & er;
      if (del) void'(qa.pop_front());
      if (flush) qa.delete();
      else if (acc) qa.push_back(data);
      delb = evb & ready_b;
      accb = valid_b & erb;
      if (delb) begin
        void'(qb.pop_front());
        delivered_b++;
      end
      if (flush_b) qb.delete();
      else if (accb) qb.push_back(data_b);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bubble_c = '0;
    bubble_c[4*DW +: DW] = 32'h0000_0013;
    delivered_b = 0;
    rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b0; data = '0;
    flush_b = 1'b0; valid_b = 1'b0; ready_b = 1'b0; data_b = '0;

    //          rst   flush valid ready f0     ev    er    ef0    stall
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 16'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 8'h22, 16'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hA1, 1'b1, 1'b1, 8'hA1, 16'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b0, 8'hA1, 16'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 8'hA1, 16'd2};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 8'hA1, 16'd3};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 8'hB2, 16'd3};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 8'hC3, 16'd3};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hD4, 1'b1, 1'b1, 8'hD4, 16'd3};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 16'd3};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hE5, 1'b1, 1'b1, 8'hE5, 16'd3};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hF6, 1'b1, 1'b0, 8'hE5, 16'd4};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b1, 8'h00, 16'd5};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'd5};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h88, 1'b1, 1'b1, 8'h88, 16'd5};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 1'b1, 8'h00, 16'd5};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 8'hAA, 16'd5};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 16'd5};
    tbl[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hBB, 1'b1, 1'b1, 8'hBB, 16'd5};
    tbl[23] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hCC, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'd0};

    @(posedge clk); #1;
    cycle(1'b0);
    cycle(1'b0);

    for (int i = 0; i < 25; i++) begin
      rst = tbl[i].rst; flush = tbl[i].flush; valid = tbl[i].valid; ready = tbl[i].ready;
      data = mk(tbl[i].f0);
      cycle(1'b1);
      chk($sformatf("vec%0d_valid", i), TW'(o_valid_a), TW'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_ready", i), TW'(o_ready_a), TW'(tbl[i].exp_ready));
      chk($sformatf("vec%0d_f0", i), TW'(o_data_a[7:0]), TW'(tbl[i].exp_f0));
      chk($sformatf("vec%0d_stall", i), TW'(stall_a), TW'(tbl[i].exp_stall));
    end
    chk("reset_instr_field", TW'(o_data_a[4*DW +: DW]), TW'(32'h0000_0013));

    // hold one entry stalled for 20 cycles: narrow counter must stop at 15
    rst = 1'b0; flush = 1'b0; valid = 1'b1; ready = 1'b0; data = mk(8'h5C);
    cycle(1'b1);
    valid = 1'b0;
    for (int i = 0; i < 20; i++) cycle(1'b1);
    chk("sat_stall_4bit", TW'(stall_s), TW'(4'd15));
    chk("sat_stall_16bit", TW'(stall_a), TW'(16'd20));
    ready = 1'b1;
    cycle(1'b1);
    chk("sat_drain_valid", TW'(o_valid_a), TW'(1'b0));
    chk("sat_hold_after_drain", TW'(stall_s), TW'(4'd15));
    ready = 1'b0;

    // single-entry variant: o_ready follows i_ready in the same cycle while full
    valid_b = 1'b1; ready_b = 1'b1; data_b = mk(8'h31);
    cycle(1'b1);
    data_b = mk(8'h32); #1;
    chk("b_follow_hi", TW'(o_ready_b), TW'(1'b1));
    cycle(1'b1);
    ready_b = 1'b0; data_b = mk(8'h33); #1;
    chk("b_follow_lo", TW'(o_ready_b), TW'(1'b0));
    cycle(1'b1);
    ready_b = 1'b1; #1;
    chk("b_follow_hi2", TW'(o_ready_b), TW'(1'b1));
    cycle(1'b1);
    valid_b = 1'b0;
    cycle(1'b1);
    cycle(1'b1);
    chk("b_delivered", TW'(delivered_b), TW'(3));
    chk("b_queue_empty", TW'(qb.size()), TW'(0));
    chk("a_queue_empty", TW'(qa.size()), TW'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline stage register for the CPU core. It replaces the fixed, enable-gated inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with a valid/ready handshake, an optional skid buffer, a synchronous flush that injects a NOP bubble, and saturating stall/bubble performance counters. It carries NUM_FIELDS fields of DATA_WIDTH bits between two adjacent pipeline stages.

## Interface
- DATA_WIDTH, 32, width of one field
- NUM_FIELDS, 5, number of fields carried (ctrl, pc_next, alu, data2, instr, ...)
- INSTR_FIELD, 4, index of the field replaced by NOP_INSTR when the stage holds no valid entry
- NOP_INSTR, 32'h0000_0013, bubble instruction value (addi x0,x0,0)
- SKID, 1, 1 = two-entry skid buffer with registered o_ready; 0 = single entry with combinational o_ready
- CNT_WIDTH, 16, width of each performance counter
- clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_flush  in  1  synchronous kill of all held entries
- i_valid  in  1  upstream entry valid
- o_ready  out  1  stage can accept an entry this cycle
- i_data  in  NUM_FIELDS*DATA_WIDTH  upstream fields; field k = bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_valid  out  1  output entry valid
- i_ready  in  1  downstream accepts the output entry
- o_data  out  NUM_FIELDS*DATA_WIDTH  output fields, same packing
- o_stall_cnt  out  CNT_WIDTH  cycles with o_valid=1 and i_ready=0
- o_bubble_cnt  out  CNT_WIDTH  cycles with o_valid=0 and i_ready=1

## Operation
- Accept = i_valid & o_ready. Deliver = o_valid & i_ready. Entries leave in arrival order; none are duplicated or dropped except by flush.
- Storage: main register (drives o_data) and, if SKID=1, a skid register. Each has a valid bit.
- States (SKID=1): EMPTY (main invalid), FULL (main valid, skid invalid), SKID_FULL (both valid).
  - EMPTY: on accept, main <= i_data and go to FULL.
  - FULL: on accept and deliver, main <= i_data and stay in FULL. On accept only, skid <= i_data and go to SKID_FULL. On deliver only, go to EMPTY. Otherwise hold.
  - SKID_FULL: no accept is possible. On deliver, main <= skid and go to FULL. Otherwise hold.
- o_ready (SKID=1) = !skid_valid, driven from a register. No combinational path from i_ready.
- SKID=0: single entry. o_ready = !o_valid | i_ready, combinational. Main loads on accept; valid clears on deliver without accept.
- Invalid output: when o_valid=0, o_data field INSTR_FIELD = NOP_INSTR and all other fields = 0. This masking is applied to the stored value, not with a combinational mux, so o_data is always a register output.
- Flush: i_flush=1 forces EMPTY. Both valid bits are cleared and main is loaded with the bubble pattern. An entry offered in the flush cycle is discarded even if o_ready=1. A deliver in the flush cycle still completes, because downstream sampled it.
- Priority: i_rst > i_flush > handshake.
- Counters: each cycle, o_stall_cnt += (o_valid & !i_ready) and o_bubble_cnt += (!o_valid & i_ready). Both saturate at 2^CNT_WIDTH-1 with no wrap. They are cleared only by i_rst; flush does not clear them.

## Timing
- Reset values: o_valid=0, o_ready=1, o_data = bubble pattern, both counters = 0, state EMPTY.
- Latency: an entry accepted at edge N is visible on o_data/o_valid after edge N. Throughput is 1 entry/cycle with no bubble when i_ready stays high.
- SKID=1: when i_ready drops, one more entry is absorbed into skid. o_ready falls 1 cycle later. After i_ready rises, o_ready returns high 1 cycle after the deliver that moves skid into main.
- Flush: o_valid=0 and o_ready=1 in the cycle after the flush edge. Accepts resume in that cycle.
- Reset asserted mid-stream: all entries are lost. Outputs take reset values after the next edge.

## Test plan
- Reset: hold i_rst 2 cycles with random inputs -> o_valid=0, o_ready=1, o_data field4=0x00000013, other fields 0, counters 0.
- Stream: i_ready=1, send A,B,C back-to-back (field0=0x11,0x22,0x33) -> o_data field0 = 0x11,0x22,0x33 on consecutive cycles, each one cycle after accept; o_stall_cnt=0.
- Skid (SKID=1): stream A,B,C,D with i_ready=0 starting when A is at output -> B is held in skid, o_ready=0, C is not accepted; after 3 stall cycles raise i_ready -> delivered order A,B,C,D; o_stall_cnt=3.
- Flush in SKID_FULL with i_valid=1, i_ready=0 -> next cycle o_valid=0, o_ready=1, field4=NOP_INSTR; the offered entry never appears at the output; counters keep their values.
- Saturation (CNT_WIDTH=4): hold o_valid=1, i_ready=0 for 20 cycles -> o_stall_cnt stops at 15.
- SKID=0: o_valid=1, i_ready toggles 1,0,1 with i_valid=1 -> o_ready follows i_ready in the same cycle; no entry is lost or duplicated.
